// File: rtl/spi_master.sv
// SPI mode 0 master (CPOL=0, CPHA=0), MSB first, fixed DATA_W-bit frames.
// SCK half-period is CLK_DIV clk cycles; frames are framed by SETUP/HOLD/GAP phases.
module spi_master #(
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy,
    output logic              SCK,
    output logic              MOSI,
    input  logic              MISO,
    output logic              SSEL
);

    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int HALF_W = $clog2(2 * DATA_W);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } state_t;

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [HALF_W-1:0]   half_q, half_d;
    logic                sck_q, sck_d;
    logic [DATA_W-1:0]   tx_sr_q, tx_sr_d;
    logic [DATA_W-1:0]   rx_sr_q, rx_sr_d;
    logic [DATA_W-1:0]   rx_data_q, rx_data_d;
    logic                rx_valid_q, rx_valid_d;
    logic                div_last;
    logic                frame_active;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            div_q      <= '0;
            half_q     <= '0;
            sck_q      <= 1'b0;
            tx_sr_q    <= '0;
            rx_sr_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            half_q     <= half_d;
            sck_q      <= sck_d;
            tx_sr_q    <= tx_sr_d;
            rx_sr_q    <= rx_sr_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    // State changes only happen when the divider wraps, so it restarts at 0 in every state.
    always_comb begin
        state_d    = state_q;
        half_d     = half_q;
        sck_d      = sck_q;
        tx_sr_d    = tx_sr_q;
        rx_sr_d    = rx_sr_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        div_last   = (div_q == DIV_W'(CLK_DIV - 1));
        div_d      = div_last ? '0 : div_q + DIV_W'(1);

        case (state_q)
            IDLE: begin
                div_d = '0;
                if (tx_valid) begin
                    tx_sr_d = tx_data;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (div_last) begin
                    state_d = SHIFT;
                    sck_d   = 1'b1;
                    half_d  = '0;
                    rx_sr_d = {rx_sr_q[DATA_W-2:0], MISO};
                end
            end
            SHIFT: begin
                if (div_last) begin
                    half_d = half_q + HALF_W'(1);
                    if (sck_q) begin
                        sck_d = 1'b0;
                        // The final falling edge leaves the LSB on MOSI instead of shifting it out.
                        if (half_q != HALF_W'(2 * DATA_W - 2)) begin
                            tx_sr_d = {tx_sr_q[DATA_W-2:0], 1'b0};
                        end
                    end else if (half_q == HALF_W'(2 * DATA_W - 1)) begin
                        state_d = HOLD;
                    end else begin
                        sck_d   = 1'b1;
                        rx_sr_d = {rx_sr_q[DATA_W-2:0], MISO};
                    end
                end
            end
            HOLD: begin
                if (div_last) begin
                    state_d    = GAP;
                    rx_data_d  = rx_sr_q;
                    rx_valid_d = 1'b1;
                end
            end
            GAP: begin
                if (div_last) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign frame_active = (state_q == SETUP) || (state_q == SHIFT) || (state_q == HOLD);

    assign tx_ready = (state_q == IDLE);
    assign busy     = (state_q != IDLE);
    assign SCK      = sck_q;
    assign SSEL     = ~frame_active;
    assign MOSI     = frame_active & tx_sr_q[DATA_W-1];
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: default instance (8-bit, CLK_DIV=2) plus a 16-bit CLK_DIV=1 instance.
module tb_spi_master;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    logic       sck, mosi, miso, ssel;

    logic [15:0] tx_data1 = 16'h0000;
    logic        tx_valid1 = 1'b0;
    logic        tx_ready1;
    logic [15:0] rx_data1;
    logic        rx_valid1;
    logic        busy1;
    logic        sck1, mosi1, ssel1;

    logic       lb = 1'b1;
    logic       miso_r = 1'b0;
    logic [7:0] slv_word = 8'h00;

    int checks = 0;
    int errors = 0;

    assign miso = lb ? mosi : miso_r;

    always #5 clk = ~clk;

    spi_master #(.DATA_W(8), .CLK_DIV(2)) dut (
        .clk(clk), .rst(rst),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy),
        .SCK(sck), .MOSI(mosi), .MISO(miso), .SSEL(ssel)
    );

    spi_master #(.DATA_W(16), .CLK_DIV(1)) dut1 (
        .clk(clk), .rst(rst),
        .tx_data(tx_data1), .tx_valid(tx_valid1), .tx_ready(tx_ready1),
        .rx_data(rx_data1), .rx_valid(rx_valid1), .busy(busy1),
        .SCK(sck1), .MOSI(mosi1), .MISO(mosi1), .SSEL(ssel1)
    );

    // Results collected by mon() over one observation window.
    int         m_ssel_first, m_ssel_last, m_ssel_low, m_hi_mid, m_fall2;
    int         m_rise_first, m_rises, m_rxv_n, m_hs2, m_unstable, m_mosi_one, m_rdy_busy;
    int         m_rxv_cyc [2];
    logic [7:0] m_rxv_dat [2];
    logic [7:0] m_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [7:0] d);
        tx_data  = d;
        tx_valid = 1'b1;
    endtask

    // Observes cycles 1..ncyc after the handshake edge; plays a slave returning slv_word when lb=0.
    task automatic mon(input int ncyc, input logic [7:0] new_tx, input int drop_at);
        logic prev_sck = 1'b0;
        logic prev_mosi = 1'b0;
        logic prev_ssel = 1'b1;
        int   falls = 0;
        int   rc = 0;
        m_ssel_first = -1; m_ssel_last = -1; m_ssel_low = 0; m_hi_mid = 0; m_fall2 = -1;
        m_rise_first = -1; m_rises = 0; m_rxv_n = 0; m_hs2 = -1; m_unstable = 0;
        m_mosi_one = 0; m_rdy_busy = 0; m_seen = 8'h00;
        m_rxv_cyc[0] = -1; m_rxv_cyc[1] = -1; m_rxv_dat[0] = 8'h00; m_rxv_dat[1] = 8'h00;
        for (int c = 1; c <= ncyc; c++) begin
            tick();
            if (!ssel) begin
                if (m_ssel_first < 0) m_ssel_first = c;
                m_ssel_last = c;
                m_ssel_low++;
                if (prev_ssel) begin
                    falls++;
                    if (falls == 2) m_fall2 = c;
                end
            end else begin
                if (falls == 1) m_hi_mid++;
                rc = 0;
                miso_r = slv_word[7];
            end
            if (sck && !prev_sck) begin
                if (m_rise_first < 0) m_rise_first = c;
                m_rises++;
                if (falls == 1) m_seen = {m_seen[6:0], mosi};
                if (mosi !== prev_mosi) m_unstable++;
                rc++;
                if (rc < 8) miso_r = slv_word[7-rc];
            end
            if (mosi) m_mosi_one++;
            if (tx_ready && !ssel) m_rdy_busy++;
            if (rx_valid) begin
                if (m_rxv_n < 2) begin
                    m_rxv_cyc[m_rxv_n] = c;
                    m_rxv_dat[m_rxv_n] = rx_data;
                end
                m_rxv_n++;
            end
            if (c > 1 && tx_ready && tx_valid && m_hs2 < 0) m_hs2 = c;
            if (c == 1) tx_data = new_tx;
            if (c == drop_at) tx_valid = 1'b0;
            prev_sck  = sck;
            prev_mosi = mosi;
            prev_ssel = ssel;
        end
    endtask

    initial begin
        int rxv_bad;
        int low1, tog1, first_tog1, rxv1_cyc;
        logic [15:0] rxv1_dat;
        logic prev_sck1;

        // Reset state
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("rst_ssel", ssel, 1'b1);
        chk("rst_sck", sck, 1'b0);
        chk("rst_mosi", mosi, 1'b0);
        chk("rst_tx_ready", tx_ready, 1'b1);
        chk("rst_rx_valid", rx_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_rx_data", rx_data, 8'h00);
        chk("rst_ssel1", ssel1, 1'b1);
        chk("rst_rx_data1", rx_data1, 16'h0000);
        tick();

        // Loopback 0xA5
        lb = 1'b1;
        start(8'hA5);
        mon(40, 8'hA5, 1);
        chk("a5_ssel_first", m_ssel_first, 1);
        chk("a5_ssel_last", m_ssel_last, 36);
        chk("a5_ssel_low", m_ssel_low, 36);
        chk("a5_rise_first", m_rise_first, 3);
        chk("a5_rises", m_rises, 8);
        chk("a5_rxv_n", m_rxv_n, 1);
        chk("a5_rxv_cyc", m_rxv_cyc[0], 37);
        chk("a5_rx_data", m_rxv_dat[0], 8'hA5);
        chk("a5_rdy_busy", m_rdy_busy, 0);
        chk("a5_idle_ready", tx_ready, 1'b1);

        // Slave returns 0x3C while master sends 0xC3
        lb = 1'b0;
        slv_word = 8'h3C;
        miso_r = slv_word[7];
        start(8'hC3);
        mon(40, 8'hC3, 1);
        chk("c3_slave_seen", m_seen, 8'hC3);
        chk("c3_mosi_stable", m_unstable, 0);
        chk("c3_rxv_n", m_rxv_n, 1);
        chk("c3_rx_data", m_rxv_dat[0], 8'h3C);
        chk("c3_rises", m_rises, 8);

        // Back-to-back 0x01 then 0x80 with tx_valid held
        lb = 1'b1;
        start(8'h01);
        mon(80, 8'h80, 40);
        chk("b2b_hs2", m_hs2, 39);
        chk("b2b_fall2", m_fall2, 40);
        chk("b2b_ssel_high", m_hi_mid, 3);
        chk("b2b_rxv_n", m_rxv_n, 2);
        chk("b2b_rxv_cyc0", m_rxv_cyc[0], 37);
        chk("b2b_rxv_cyc1", m_rxv_cyc[1], 76);
        chk("b2b_rx0", m_rxv_dat[0], 8'h01);
        chk("b2b_rx1", m_rxv_dat[1], 8'h80);
        chk("b2b_rdy_busy", m_rdy_busy, 0);
        chk("b2b_rises", m_rises, 16);

        // Reset at cycle 10 of a frame
        start(8'h96);
        rxv_bad = 0;
        for (int c = 1; c <= 9; c++) begin
            tick();
            if (rx_valid) rxv_bad++;
            if (c == 1) tx_valid = 1'b0;
        end
        tick();
        rst = 1'b1;
        tick();
        if (rx_valid) rxv_bad++;
        chk("mrst_ssel", ssel, 1'b1);
        chk("mrst_sck", sck, 1'b0);
        chk("mrst_mosi", mosi, 1'b0);
        chk("mrst_tx_ready", tx_ready, 1'b1);
        chk("mrst_busy", busy, 1'b0);
        chk("mrst_rx_data", rx_data, 8'h00);
        chk("mrst_no_rxv", rxv_bad, 0);
        rst = 1'b0;
        start(8'h5A);
        mon(40, 8'h5A, 1);
        chk("post_rst_rxv_n", m_rxv_n, 1);
        chk("post_rst_rx", m_rxv_dat[0], 8'h5A);
        chk("post_rst_rxv_cyc", m_rxv_cyc[0], 37);

        // tx_data changed after handshake of 0x00
        start(8'h00);
        mon(40, 8'hFF, 1);
        chk("late_tx_mosi_one", m_mosi_one, 0);
        chk("late_tx_rx", m_rxv_dat[0], 8'h00);
        chk("late_tx_ssel_low", m_ssel_low, 36);

        // 16-bit CLK_DIV=1 loopback 0xBEEF
        tx_data1  = 16'hBEEF;
        tx_valid1 = 1'b1;
        low1 = 0; tog1 = 0; first_tog1 = -1; rxv1_cyc = -1; rxv1_dat = 16'h0000;
        prev_sck1 = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (c == 1) tx_valid1 = 1'b0;
            if (!ssel1) low1++;
            if (sck1 !== prev_sck1) begin
                if (first_tog1 < 0) first_tog1 = c;
                tog1++;
            end
            if (rx_valid1 && rxv1_cyc < 0) begin
                rxv1_cyc = c;
                rxv1_dat = rx_data1;
            end
            prev_sck1 = sck1;
        end
        chk("w16_ssel_low", low1, 34);
        chk("w16_sck_toggles", tog1, 32);
        chk("w16_first_toggle", first_tog1, 2);
        chk("w16_rxv_cyc", rxv1_cyc, 35);
        chk("w16_rx_data", rxv1_dat, 16'hBEEF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
